// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared constants for the multi-cycle MIPS datapath: data/index widths,
//   architecturally special register indices, the stack-pointer reset value,
//   and the RegDst destination-mux select encoding with a helper that
//   resolves a select into a register index.
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int unsigned SP_INIT = 227;

    // RegDst mux select: which field or fixed register becomes the write index.
    typedef enum logic [2:0] {
        REGDST_RT = 3'd0,
        REGDST_RD = 3'd1,
        REGDST_RS = 3'd2,
        REGDST_SP = 3'd3,
        REGDST_RA = 3'd4
    } regdst_sel_e;

    function automatic logic [4:0] regdst_addr(input regdst_sel_e sel,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [4:0]  rd);
        logic [4:0] addr;
        case (sel)
            REGDST_RT: addr = rt;
            REGDST_RD: addr = rd;
            REGDST_RS: addr = rs;
            REGDST_SP: addr = REG_SP;
            REGDST_RA: addr = REG_RA;
            default:   addr = rt;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/ab_latch.sv
// ----------------------------------------------------------------------------
// ab_latch
//   Operand holding register (A or B) with load enable.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset, clears q
//     load   in   capture d on the next rising edge, otherwise hold
//     d      in   DATA_W operand from a register-bank read port
//     q      out  DATA_W registered operand
// ----------------------------------------------------------------------------
module ab_latch
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_ab.sv
// ----------------------------------------------------------------------------
// reg_bank_ab
//   32x32 general-purpose register bank for the multi-cycle MIPS datapath,
//   with the A/B operand registers that feed the ALU-source muxes.
//   $0 reads as zero and ignores writes; $SP_IDX resets to SP_INIT.
//
//   Build option: define REG_BANK_BYPASS_EN to forward write_data onto a
//   read port whose index matches an active write in the same cycle
//   (write-through). Without it a same-cycle read returns the old value.
//
//   Ports:
//     clk         in   rising-edge clock
//     reset_n     in   asynchronous active-low reset
//     reg_write   in   write enable
//     write_addr  in   ADDR_W destination index (RegDst mux output)
//     write_data  in   DATA_W write-back data (MemToReg mux output)
//     read_addr1  in   ADDR_W rs index
//     read_addr2  in   ADDR_W rt index
//     a_load      in   capture read_data1 into a_out
//     b_load      in   capture read_data2 into b_out
//     read_data1  out  DATA_W combinational read of read_addr1
//     read_data2  out  DATA_W combinational read of read_addr2
//     a_out       out  DATA_W registered operand A
//     b_out       out  DATA_W registered operand B
// ----------------------------------------------------------------------------
module reg_bank_ab
    import mips_pkg::*;
#(
    parameter int          DATA_W  = mips_pkg::DATA_W,
    parameter int          ADDR_W  = mips_pkg::ADDR_W,
    parameter int          SP_IDX  = 29,
    parameter int unsigned SP_INIT = mips_pkg::SP_INIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    input  logic              a_load,
    input  logic              b_load,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);

    localparam int                NREG      = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] SP_RESET  = DATA_W'(SP_INIT);

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_en;

    // $0 is never stored to, so its array slot stays at its reset value.
    assign wr_en = reg_write && (write_addr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else if (wr_en) begin
            regs[write_addr] <= write_data;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    // Write-through: a matching in-flight write wins over the stored value,
    // so an operand register loaded this cycle already sees the new data.
    logic fwd1, fwd2;

    assign fwd1 = wr_en && (write_addr == read_addr1);
    assign fwd2 = wr_en && (write_addr == read_addr2);

    assign read_data1 = (read_addr1 == '0) ? '0 :
                        fwd1               ? write_data : regs[read_addr1];
    assign read_data2 = (read_addr2 == '0) ? '0 :
                        fwd2               ? write_data : regs[read_addr2];
`else
    assign read_data1 = (read_addr1 == '0) ? '0 : regs[read_addr1];
    assign read_data2 = (read_addr2 == '0) ? '0 : regs[read_addr2];
`endif

    ab_latch #(.DATA_W(DATA_W)) u_a_latch (
        .clk   (clk),
        .rst_n (reset_n),
        .load  (a_load),
        .d     (read_data1),
        .q     (a_out)
    );

    ab_latch #(.DATA_W(DATA_W)) u_b_latch (
        .clk   (clk),
        .rst_n (reset_n),
        .load  (b_load),
        .d     (read_data2),
        .q     (b_out)
    );

endmodule

// File: tb/tb_reg_bank_ab.sv
// ----------------------------------------------------------------------------
// tb_reg_bank_ab
//   Directed bench for reg_bank_ab. Inputs change 1 time unit after a rising
//   edge; outputs are sampled mid-cycle. REG_BANK_BYPASS_EN selects the
//   expected same-cycle forwarding result.
// ----------------------------------------------------------------------------
module tb_reg_bank_ab;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic        a_load;
    logic        b_load;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] a_out;
    logic [31:0] b_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_bank_ab dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .a_load     (a_load),
        .b_load     (b_load),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .a_out      (a_out),
        .b_out      (b_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Protocol monitor: an unknown destination index during a write.
    always @(posedge clk) begin
        if (reset_n === 1'b1 && reg_write === 1'b1 && $isunknown(write_addr)) begin
            n_errors++;
            $display("FAIL proto_waddr_x: got %b expected known index", write_addr);
        end
    end

    // Called 1 unit after a rising edge; returns 1 unit after the next one.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write  = 1'b1;
        write_addr = a;
        write_data = d;
        @(posedge clk); #1;
        reg_write  = 1'b0;
    endtask

    task automatic rd1(input string tag, input logic [4:0] a, input logic [31:0] exp);
        read_addr1 = a;
        #1;
        check_eq(tag, read_data1, exp);
    endtask

    task automatic rd2(input string tag, input logic [4:0] a, input logic [31:0] exp);
        read_addr2 = a;
        #1;
        check_eq(tag, read_data2, exp);
    endtask

    task automatic load_ab(input logic la, input logic lb);
        a_load = la;
        b_load = lb;
        @(posedge clk); #1;
        a_load = 1'b0;
        b_load = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'h0101_0101 * i) ^ 32'hA5A5_0000;
    endfunction

    logic [31:0] exp_same;

    initial begin
        reset_n    = 1'b0;
        reg_write  = 1'b0;
        write_addr = '0;
        write_data = '0;
        read_addr1 = '0;
        read_addr2 = '0;
        a_load     = 1'b0;
        b_load     = 1'b0;

        // Release reset mid-cycle, then check the full reset image on both ports.
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            rd1($sformatf("rst_p1_r%0d", i), 5'(i), (i == 29) ? 32'd227 : 32'd0);
            rd2($sformatf("rst_p2_r%0d", i), 5'(i), (i == 29) ? 32'd227 : 32'd0);
        end
        check_eq("rst_a_out", a_out, 32'd0);
        check_eq("rst_b_out", b_out, 32'd0);

        // Basic write, then capture into A only; B must hold.
        wr(5'd8, 32'hDEAD_BEEF);
        rd1("wr8_p1", 5'd8, 32'hDEAD_BEEF);
        rd2("wr8_p2", 5'd8, 32'hDEAD_BEEF);
        load_ab(1'b1, 1'b0);
        check_eq("a_load_8", a_out, 32'hDEAD_BEEF);
        check_eq("b_hold_0", b_out, 32'd0);

        // Both latches in the same cycle from different registers.
        wr(5'd9, 32'h1234_5678);
        read_addr1 = 5'd9;
        read_addr2 = 5'd8;
        load_ab(1'b1, 1'b1);
        check_eq("ab_both_a", a_out, 32'h1234_5678);
        check_eq("ab_both_b", b_out, 32'hDEAD_BEEF);
        read_addr1 = 5'd0;
        load_ab(1'b0, 1'b0);
        check_eq("a_hold", a_out, 32'h1234_5678);

        // Writes to $0 are dropped.
        wr(5'd0, 32'hFFFF_FFFF);
        rd1("zero_p1", 5'd0, 32'd0);
        rd2("zero_p2", 5'd0, 32'd0);

        // RegDst fixed targets $31 and $29.
        wr(5'd31, 32'h11);
        wr(5'd29, 32'h22);
        rd1("ra_p1", 5'd31, 32'h11);
        rd2("sp_p2", 5'd29, 32'h22);

        // Distinct pattern in every register, read back on both ports.
        for (int i = 1; i < 32; i++) wr(5'(i), pat(i));
        for (int i = 0; i < 32; i++) begin
            rd1($sformatf("pat_p1_r%0d", i), 5'(i), (i == 0) ? 32'd0 : pat(i));
            rd2($sformatf("pat_p2_r%0d", 31 - i), 5'(31 - i), (i == 31) ? 32'd0 : pat(31 - i));
        end

        // Same-cycle write and read of $5 with A loading.
        wr(5'd5, 32'd1);
`ifdef REG_BANK_BYPASS_EN
        exp_same = 32'd2;
`else
        exp_same = 32'd1;
`endif
        reg_write  = 1'b1;
        write_addr = 5'd5;
        write_data = 32'd2;
        read_addr1 = 5'd5;
        a_load     = 1'b1;
        #1;
        check_eq("same_cyc_rd", read_data1, exp_same);
        @(posedge clk); #1;
        reg_write = 1'b0;
        a_load    = 1'b0;
        check_eq("same_cyc_a", a_out, exp_same);
        rd1("same_cyc_after", 5'd5, 32'd2);

        // Load B with a nonzero value so the async clear is observable.
        read_addr2 = 5'd8;
        load_ab(1'b0, 1'b1);
        check_eq("pre_rst_b", b_out, pat(8));

        // Reset asserted mid-cycle while a write of $3 is pending.
        reg_write  = 1'b1;
        write_addr = 5'd3;
        write_data = 32'h55;
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_a_clr", a_out, 32'd0);
        check_eq("async_b_clr", b_out, 32'd0);
        rd1("async_sp", 5'd29, 32'd227);
        rd2("async_r8", 5'd8, 32'd0);
        @(posedge clk); #1;
        reg_write = 1'b0;
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        rd1("rst_wr_r3", 5'd3, 32'd0);
        rd2("rst_wr_r31", 5'd31, 32'd0);
        rd1("rst_wr_sp", 5'd29, 32'd227);

        // Bank is writable again after reset.
        wr(5'd3, 32'h55);
        rd2("post_rst_r3", 5'd3, 32'h55);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
